control_unit: RTL
=================

// Module: control_unit
// PURPOSE
//  Multicycle Moore FSM sequencing the processor datapath: PC, memory, IR, register bank, A/B, ALU, ALUOut, muxes.
//  Decodes opcode/funct from IR and drives every load/write enable and mux select, one micro-step per clock.
//  Handles ALU overflow and illegal opcodes by vectoring the PC. Handles BREAK by halting until reset.
// PARAMETERS
//  MEM_LATENCY  1  extra wait cycles per memory read (FETCH, MEM_READ); legal 0..7
// PORTS
//  clk          in   1  system clock, rising edge
//  rst          in   1  asynchronous, active-high reset
//  opcode       in   6  IR[31:26]
//  funct        in   6  IR[5:0]
//  alu_zero     in   1  ALU zero flag
//  alu_overflow in   1  ALU overflow flag
//  pc_load      out  1  PC load enable
//  pc_src       out  2  00 ALU result, 01 ALUOut, 10 jump addr, 11 exception vector
//  iord         out  1  mem address select: 0 PC, 1 ALUOut
//  mem_write    out  1  memory write enable
//  ir_write     out  1  IR load enable
//  reg_dst      out  2  write reg select: 00 rt, 01 rd
//  mem_to_reg   out  3  write data select: 000 ALUOut, 001 mem_out
//  reg_write    out  1  register bank write enable
//  regA_load    out  1  A load enable
//  regB_load    out  1  B load enable
//  alu_srcA     out  1  0 PC, 1 A
//  alu_srcB     out  2  00 B, 01 const 4, 10 sext(imm), 11 sext(imm)<<2
//  alu_op       out  3  001 add, 010 sub, 011 and
//  aluout_load  out  1  ALUOut load enable
//  exc_cause    out  2  00 none, 01 overflow, 10 illegal opcode; registered, holds until next exception/reset
//  halted       out  1  high while in HALT
// BEHAVIOUR
//  - rst high: state=RESET, wait counter=0, exc_cause=00. All enables 0; selects 0.
//    Reset mid-instruction aborts it with no further writes.
//  - Outputs are decoded from the state register only, and held stable for the whole state.
//    Exception: pc_load in BRANCH depends on alu_zero.
//  - RESET -> FETCH on first clock after rst falls.
//  - FETCH lasts MEM_LATENCY+1 cycles (counter). Throughout: iord=0, alu_srcA=0, alu_srcB=01, alu_op=add.
//    ir_write and pc_load (pc_src=00) are asserted in its last cycle only -> DECODE.
//  - DECODE (1 cyc): regA_load, regB_load. ALUOut <= PC+(sext(imm)<<2) (srcA=0, srcB=11, add, aluout_load).
//  - DECODE dispatch:
//      R-type add/sub/and -> R_EXEC.  addi -> I_EXEC.  lw/sw -> MEM_ADDR.  beq/bne -> BRANCH.
//      j -> JUMP.  R-type funct BREAK(0x0D) -> HALT.  Any other opcode/funct -> EXC (cause 10).
//  - R_EXEC: srcA=1, srcB=00, op per funct, aluout_load. Next is R_WB, or EXC (cause 01) if alu_overflow on add/sub.
//  - R_WB: reg_dst=01, mem_to_reg=000, reg_write -> FETCH.
//  - I_EXEC: srcA=1, srcB=10, add, aluout_load. Next is I_WB, or EXC (cause 01) on overflow.
//  - I_WB: reg_dst=00, mem_to_reg=000, reg_write -> FETCH.
//  - MEM_ADDR: srcA=1, srcB=10, add, aluout_load (no overflow check).
//    Next is MEM_READ (lw) or MEM_WRITE (sw).
//  - MEM_READ: iord=1, lasts MEM_LATENCY+1 cycles -> MEM_WB.
//  - MEM_WB: reg_dst=00, mem_to_reg=001, reg_write -> FETCH.
//  - MEM_WRITE (1 cyc): iord=1, mem_write -> FETCH.
//  - BRANCH: srcA=1, srcB=00, sub, pc_src=01. pc_load = alu_zero (beq) or !alu_zero (bne) -> FETCH.
//  - JUMP: pc_src=10, pc_load -> FETCH.
//  - EXC (1 cyc): pc_src=11, pc_load, exc_cause updated. No reg/mem write in the faulting instruction -> FETCH.
//  - HALT: all enables 0, halted=1. Exits only via rst.
//  - Cycles with MEM_LATENCY=1: R/addi/sw 5, lw 7, beq/bne/j 4.
// TESTING
//  - rst pulse mid-lw (during MEM_READ) -> all enables 0 asynchronously; after release FETCH, no reg_write seen.
//  - add (op 0, funct 0x20), no overflow -> exactly 5 cycles; reg_write 1 cycle in cycle 5 with reg_dst=01.
//  - lw, MEM_LATENCY=1 and =3 -> reg_write in cycle 7 and cycle 11; iord=1 during MEM_READ.
//  - beq with alu_zero=1 then 0 -> pc_load in cycle 4 with pc_src=01, then no pc_load in cycle 4.
//  - addi with alu_overflow=1 in I_EXEC -> no reg_write; EXC next; pc_src=11, exc_cause=01.
//  - opcode 0x3E -> EXC, exc_cause=10. Next, BREAK -> halted=1 held 100 cycles until rst.

Source files
------------

// File: rtl/control_unit.sv
// Multicycle Moore control unit: sequences fetch/decode/execute/writeback micro-steps
// and drives every datapath enable and mux select from registered state.
module control_unit #(
  parameter int MEM_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  input  logic       alu_overflow,
  output logic       pc_load,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] reg_dst,
  output logic [2:0] mem_to_reg,
  output logic       reg_write,
  output logic       regA_load,
  output logic       regB_load,
  output logic       alu_srcA,
  output logic [1:0] alu_srcB,
  output logic [2:0] alu_op,
  output logic       aluout_load,
  output logic [1:0] exc_cause,
  output logic       halted
);

  typedef enum logic [3:0] {
    S_RESET     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_R_EXEC    = 4'd3,
    S_R_WB      = 4'd4,
    S_I_EXEC    = 4'd5,
    S_I_WB      = 4'd6,
    S_MEM_ADDR  = 4'd7,
    S_MEM_READ  = 4'd8,
    S_MEM_WB    = 4'd9,
    S_MEM_WRITE = 4'd10,
    S_BRANCH    = 4'd11,
    S_JUMP      = 4'd12,
    S_EXC       = 4'd13,
    S_HALT      = 4'd14
  } state_t;

  typedef struct packed {
    logic       pc_load;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic [2:0] mem_to_reg;
    logic       reg_write;
    logic       rega_load;
    logic       regb_load;
    logic       alu_srca;
    logic [1:0] alu_srcb;
    logic [2:0] alu_op;
    logic       aluout_load;
    logic       halted;
    logic       branch;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{default: '0};

  localparam logic [2:0] LAT = 3'(MEM_LATENCY);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_BREAK = 6'h0D;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;

  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;

  localparam logic [1:0] CAUSE_OVF = 2'b01;
  localparam logic [1:0] CAUSE_ILL = 2'b10;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [1:0] exc_cause_q, exc_cause_d;
  logic [2:0] rop_q, rop_d;
  logic       is_bne_q, is_bne_d;
  logic       is_sw_q, is_sw_d;
  logic       chk_ovf_q, chk_ovf_d;
  ctrl_t      ctrl_q, ctrl_d;

  // Next-state sequencing; instruction class is latched in DECODE so later states
  // never depend on the IR contents.
  always_comb begin
    state_d     = state_q;
    cnt_d       = 3'd0;
    exc_cause_d = exc_cause_q;
    rop_d       = rop_q;
    is_bne_d    = is_bne_q;
    is_sw_d     = is_sw_q;
    chk_ovf_d   = chk_ovf_q;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        if (cnt_q == LAT) begin
          state_d = S_DECODE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE: begin
            case (funct)
              FN_ADD: begin
                state_d   = S_R_EXEC;
                rop_d     = ALU_ADD;
                chk_ovf_d = 1'b1;
              end
              FN_SUB: begin
                state_d   = S_R_EXEC;
                rop_d     = ALU_SUB;
                chk_ovf_d = 1'b1;
              end
              FN_AND: begin
                state_d   = S_R_EXEC;
                rop_d     = ALU_AND;
                chk_ovf_d = 1'b0;
              end
              FN_BREAK: state_d = S_HALT;
              default: begin
                state_d     = S_EXC;
                exc_cause_d = CAUSE_ILL;
              end
            endcase
          end
          OP_ADDI: state_d = S_I_EXEC;
          OP_LW: begin
            state_d = S_MEM_ADDR;
            is_sw_d = 1'b0;
          end
          OP_SW: begin
            state_d = S_MEM_ADDR;
            is_sw_d = 1'b1;
          end
          OP_BEQ: begin
            state_d  = S_BRANCH;
            is_bne_d = 1'b0;
          end
          OP_BNE: begin
            state_d  = S_BRANCH;
            is_bne_d = 1'b1;
          end
          OP_J: state_d = S_JUMP;
          default: begin
            state_d     = S_EXC;
            exc_cause_d = CAUSE_ILL;
          end
        endcase
      end
      S_R_EXEC: begin
        if (chk_ovf_q && alu_overflow) begin
          state_d     = S_EXC;
          exc_cause_d = CAUSE_OVF;
        end else begin
          state_d = S_R_WB;
        end
      end
      S_I_EXEC: begin
        if (alu_overflow) begin
          state_d     = S_EXC;
          exc_cause_d = CAUSE_OVF;
        end else begin
          state_d = S_I_WB;
        end
      end
      S_MEM_ADDR: begin
        if (is_sw_q) begin
          state_d = S_MEM_WRITE;
        end else begin
          state_d = S_MEM_READ;
        end
      end
      S_MEM_READ: begin
        if (cnt_q == LAT) begin
          state_d = S_MEM_WB;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_R_WB, S_I_WB, S_MEM_WB, S_MEM_WRITE,
      S_BRANCH, S_JUMP, S_EXC: state_d = S_FETCH;
      S_HALT: state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
  end

  // Control word for the state being entered, so outputs come straight from flops.
  always_comb begin
    ctrl_d = CTRL_IDLE;
    case (state_d)
      S_FETCH: begin
        ctrl_d.alu_srcb = 2'b01;
        ctrl_d.alu_op   = ALU_ADD;
        if (cnt_d == LAT) begin
          ctrl_d.ir_write = 1'b1;
          ctrl_d.pc_load  = 1'b1;
        end else begin
          ctrl_d.ir_write = 1'b0;
          ctrl_d.pc_load  = 1'b0;
        end
      end
      S_DECODE: begin
        ctrl_d.rega_load   = 1'b1;
        ctrl_d.regb_load   = 1'b1;
        ctrl_d.alu_srcb    = 2'b11;
        ctrl_d.alu_op      = ALU_ADD;
        ctrl_d.aluout_load = 1'b1;
      end
      S_R_EXEC: begin
        ctrl_d.alu_srca    = 1'b1;
        ctrl_d.alu_srcb    = 2'b00;
        ctrl_d.alu_op      = rop_d;
        ctrl_d.aluout_load = 1'b1;
      end
      S_I_EXEC, S_MEM_ADDR: begin
        ctrl_d.alu_srca    = 1'b1;
        ctrl_d.alu_srcb    = 2'b10;
        ctrl_d.alu_op      = ALU_ADD;
        ctrl_d.aluout_load = 1'b1;
      end
      S_R_WB: begin
        ctrl_d.reg_dst   = 2'b01;
        ctrl_d.reg_write = 1'b1;
      end
      S_I_WB: ctrl_d.reg_write = 1'b1;
      S_MEM_READ: ctrl_d.iord = 1'b1;
      S_MEM_WB: begin
        ctrl_d.mem_to_reg = 3'b001;
        ctrl_d.reg_write  = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl_d.iord      = 1'b1;
        ctrl_d.mem_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl_d.alu_srca = 1'b1;
        ctrl_d.alu_op   = ALU_SUB;
        ctrl_d.pc_src   = 2'b01;
        ctrl_d.branch   = 1'b1;
      end
      S_JUMP: begin
        ctrl_d.pc_src  = 2'b10;
        ctrl_d.pc_load = 1'b1;
      end
      S_EXC: begin
        ctrl_d.pc_src  = 2'b11;
        ctrl_d.pc_load = 1'b1;
      end
      S_HALT: ctrl_d.halted = 1'b1;
      default: ctrl_d = CTRL_IDLE;
    endcase
  end

  // State, latched decode flags and control word registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RESET;
      cnt_q       <= 3'd0;
      exc_cause_q <= 2'b00;
      rop_q       <= ALU_ADD;
      is_bne_q    <= 1'b0;
      is_sw_q     <= 1'b0;
      chk_ovf_q   <= 1'b0;
      ctrl_q      <= CTRL_IDLE;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      exc_cause_q <= exc_cause_d;
      rop_q       <= rop_d;
      is_bne_q    <= is_bne_d;
      is_sw_q     <= is_sw_d;
      chk_ovf_q   <= chk_ovf_d;
      ctrl_q      <= ctrl_d;
    end
  end

  // The only Mealy term: branch taken is decided by the live zero flag.
  assign pc_load     = ctrl_q.pc_load | (ctrl_q.branch & (alu_zero ^ is_bne_q));
  assign pc_src      = ctrl_q.pc_src;
  assign iord        = ctrl_q.iord;
  assign mem_write   = ctrl_q.mem_write;
  assign ir_write    = ctrl_q.ir_write;
  assign reg_dst     = ctrl_q.reg_dst;
  assign mem_to_reg  = ctrl_q.mem_to_reg;
  assign reg_write   = ctrl_q.reg_write;
  assign regA_load   = ctrl_q.rega_load;
  assign regB_load   = ctrl_q.regb_load;
  assign alu_srcA    = ctrl_q.alu_srca;
  assign alu_srcB    = ctrl_q.alu_srcb;
  assign alu_op      = ctrl_q.alu_op;
  assign aluout_load = ctrl_q.aluout_load;
  assign exc_cause   = exc_cause_q;
  assign halted      = ctrl_q.halted;

endmodule
